alu_seq_arbiter: RTL and testbench

Shares the single 8-bit ALU between two requesters and sequences every 16-bit operation as a low-byte pass followed by a high-byte pass.
- Requester 0 is the keypad/calculator path; requester 1 is a second master, e.g. a replay or test source.
- Arbitration is round-robin. Operands are latched at grant.
- The result and flags are returned with a one-cycle ack, and the same pulse can drive the Music start input.

---
 rtl/alu_seq_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_seq_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_arbiter.sv
// rtl/alu_seq_arbiter.sv - round-robin sharing of an 8-bit ALU for 16-bit two-pass operations
module alu_seq_arbiter #(
    parameter bit FIRST_GRANT = 1'b0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req0,
    input  logic [2:0]  op0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        req1,
    input  logic [2:0]  op1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] s,
    output logic [2:0]  flags,
    output logic        busy,
    output logic [2:0]  alu_cs,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    input  logic [7:0]  alu_s,
    input  logic        alu_zero,
    input  logic        alu_cout
);

    localparam logic [2:0] OP_AD = 3'd0;
    localparam logic [2:0] OP_SB = 3'd1;
    localparam logic [2:0] OP_AN = 3'd2;
    localparam logic [2:0] OP_OR = 3'd3;
    localparam logic [2:0] OP_LS = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t      state;
    logic        last_grant;
    logic        id_q;
    logic [2:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  res_lo;
    logic        low_z;

    logic        grant_id;
    logic [2:0]  sel_op;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic [2:0]  sel_cs;
    logic        chain;
    logic        ovf;
    logic        cmp;
    logic [15:0] nxt_s;
    logic [2:0]  nxt_flags;

    // Contended requests go to whoever was not served last.
    assign grant_id = (req0 && req1) ? ~last_grant : req1;
    assign sel_op   = grant_id ? op1 : op0;
    assign sel_a    = grant_id ? a1 : a0;
    assign sel_b    = grant_id ? b1 : b0;
    assign sel_cs   = (sel_op == OP_LS) ? OP_SB : (sel_op > OP_LS) ? OP_AN : sel_op;
    assign chain    = (op_q == OP_AD) || (op_q == OP_SB) || (op_q == OP_LS);

    // Signed less-than from the high-byte difference and its overflow.
    assign ovf = (a_q[15] ^ b_q[15]) & (a_q[15] ^ alu_s[7]);
    assign cmp = alu_s[7] ^ ovf;

    always_comb begin
        nxt_s     = {alu_s, res_lo};
        nxt_flags = {1'b0, low_z & alu_zero,
                     ((op_q == OP_AD) || (op_q == OP_SB)) ? alu_cout : 1'b0};
        if (op_q == OP_LS) begin
            nxt_s     = {15'b0, cmp};
            nxt_flags = {cmp, 2'b00};
        end else if (op_q > OP_LS) begin
            nxt_s     = 16'h0000;
            nxt_flags = 3'b000;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= S_IDLE;
            last_grant <= ~FIRST_GRANT;
            id_q       <= 1'b0;
            op_q       <= OP_AN;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            res_lo     <= 8'h00;
            low_z      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            s          <= 16'h0000;
            flags      <= 3'b000;
            busy       <= 1'b0;
            alu_cs     <= OP_AN;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_cin    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        alu_cs     <= sel_cs;
                        alu_a      <= sel_a[7:0];
                        alu_b      <= sel_b[7:0];
                        alu_cin    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_LOW;
                    end
                end
                S_LOW: begin
                    res_lo  <= alu_s;
                    low_z   <= alu_zero;
                    alu_a   <= a_q[15:8];
                    alu_b   <= b_q[15:8];
                    alu_cin <= chain & alu_cout;
                    state   <= S_HIGH;
                end
                S_HIGH: begin
                    s       <= nxt_s;
                    flags   <= nxt_flags;
                    ack0    <= ~id_q;
                    ack1    <= id_q;
                    alu_cs  <= OP_AN;
                    alu_a   <= 8'h00;
                    alu_b   <= 8'h00;
                    alu_cin <= 1'b0;
                    state   <= S_DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// tb/tb_alu_seq_arbiter.sv - randomized and directed bench for alu_seq_arbiter
module tb_alu_seq_arbiter;

    localparam bit FG = 1'b0;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        r_req [2];
    logic [2:0]  r_op  [2];
    logic [15:0] r_a   [2];
    logic [15:0] r_b   [2];
    logic        ack0, ack1, busy, alu_cin, alu_zero, alu_cout;
    logic [15:0] s;
    logic [2:0]  flags, alu_cs;
    logic [7:0]  alu_a, alu_b, alu_s;
    logic [8:0]  alu_w;

    int total_cnt = 0;
    int bad_cnt   = 0;
    bit chk_on    = 0;

    always #5 Clock = ~Clock;

    alu_seq_arbiter #(.FIRST_GRANT(FG)) dut (
        .Clock(Clock), .Reset(Reset),
        .req0(r_req[0]), .op0(r_op[0]), .a0(r_a[0]), .b0(r_b[0]),
        .req1(r_req[1]), .op1(r_op[1]), .a1(r_a[1]), .b1(r_b[1]),
        .ack0(ack0), .ack1(ack1), .s(s), .flags(flags), .busy(busy),
        .alu_cs(alu_cs), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_s(alu_s), .alu_zero(alu_zero), .alu_cout(alu_cout)
    );

    // External 8-bit ALU
    always_comb begin
        alu_w = 9'h000;
        case (alu_cs)
            3'd0: alu_w = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
            3'd1: alu_w = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin};
            3'd2: alu_w = {1'b0, alu_a & alu_b};
            3'd3: alu_w = {1'b0, alu_a | alu_b};
            default: alu_w = 9'h000;
        endcase
    end
    assign alu_s    = alu_w[7:0];
    assign alu_cout = alu_w[8];
    assign alu_zero = (alu_w[7:0] == 8'h00);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {compare, zero, carry, s} from whole-word arithmetic.
    function automatic logic [18:0] ref_calc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic lt;
        lt = ($signed(a) < $signed(b));
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; return {1'b0, w[15:0] == 16'h0, w[16], w[15:0]}; end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; return {1'b0, w[15:0] == 16'h0, a < b, w[15:0]}; end
            3'd2: return {1'b0, (a & b) == 16'h0, 1'b0, a & b};
            3'd3: return {1'b0, (a | b) == 16'h0, 1'b0, a | b};
            3'd4: return {lt, 2'b00, 15'b0, lt};
            default: return 19'h0;
        endcase
    endfunction

    function automatic logic low_carry(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (op == 3'd0) return ({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255;
        if (op == 3'd1 || op == 3'd4) return a[7:0] < b[7:0];
        return 1'b0;
    endfunction

    // Transaction-level model: phase counts cycles since grant (0 = idle).
    int          m_phase = 0;
    bit          m_last  = ~FG;
    bit          m_g     = 0;
    logic [2:0]  m_op;
    logic [15:0] m_a, m_b, m_s;
    logic [2:0]  m_f;
    logic [18:0] m_r;

    always @(posedge Clock) begin
        if (!Reset) begin
            m_phase = 0; m_last = ~FG; m_s = 16'h0; m_f = 3'b0;
        end else if (m_phase == 0) begin
            if (r_req[0] || r_req[1]) begin
                m_g = (r_req[0] && r_req[1]) ? !m_last : r_req[1];
                m_last = m_g;
                m_op = r_op[m_g]; m_a = r_a[m_g]; m_b = r_b[m_g];
                m_phase = 1;
            end
        end else if (m_phase == 2) begin
            m_r = ref_calc(m_op, m_a, m_b);
            m_s = m_r[15:0]; m_f = m_r[18:16];
            m_phase = 3;
        end else begin
            m_phase = (m_phase == 3) ? 0 : m_phase + 1;
        end
    end

    always @(negedge Clock) begin
        logic [2:0] e_cs;
        logic [7:0] e_a, e_b;
        logic       e_cin;
        if (chk_on) begin
            e_cs = 3'd2; e_a = 8'h0; e_b = 8'h0; e_cin = 1'b0;
            if (m_phase == 1 || m_phase == 2) begin
                e_cs = (m_op == 3'd4) ? 3'd1 : (m_op > 3'd4) ? 3'd2 : m_op;
                e_a  = (m_phase == 1) ? m_a[7:0] : m_a[15:8];
                e_b  = (m_phase == 1) ? m_b[7:0] : m_b[15:8];
                e_cin = (m_phase == 2) ? low_carry(m_op, m_a, m_b) : 1'b0;
            end
            check("ack0", ack0, (m_phase == 3) && (m_g == 0));
            check("ack1", ack1, (m_phase == 3) && (m_g == 1));
            check("busy", busy, m_phase != 0);
            check("s", s, m_s);
            check("flags", flags, m_f);
            check("alu_cs", alu_cs, e_cs);
            check("alu_a", alu_a, e_a);
            check("alu_b", alu_b, e_b);
            check("alu_cin", alu_cin, e_cin);
        end
    end

    task automatic run_op(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic [2:0] ef, input bit mutate, input string nm);
        int n;
        bit got;
        r_op[id] = op; r_a[id] = a; r_b[id] = b; r_req[id] = 1'b1;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge Clock);
            n++;
            if (mutate && n == 1) begin r_a[id] = ~a; r_b[id] = ~b; r_op[id] = 3'd3; end
            if ((id == 0 && ack0) || (id == 1 && ack1)) got = 1;
        end
        check({nm, "_ack"}, got, 1);
        check({nm, "_lat"}, n, 3);
        check({nm, "_s"}, s, es);
        check({nm, "_flags"}, flags, ef);
        r_req[id] = 1'b0;
        @(negedge Clock);
    endtask

    task automatic new_operands(input int i);
        r_op[i] = 3'($urandom_range(7));
        case ($urandom_range(3))
            0: r_a[i] = ($urandom_range(1) == 1) ? 16'hFFFF : 16'h8000;
            1: r_a[i] = 16'($urandom_range(2));
            default: r_a[i] = 16'($urandom);
        endcase
        r_b[i] = ($urandom_range(3) == 0) ? r_a[i] : 16'($urandom);
    endtask

    initial begin
        int seq [4];
        int k, n;
        bit acked, in_srv;
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0; r_op[i] = 3'd0; r_a[i] = 16'h0; r_b[i] = 16'h0;
        end
        repeat (2) @(negedge Clock);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);
        check("rst_s", s, 16'h0);
        check("rst_flags", flags, 3'b0);
        chk_on = 1;
        Reset = 1'b1;
        @(negedge Clock);

        // ALU byte sequence of the first add
        r_op[0] = 3'd0; r_a[0] = 16'h12F0; r_b[0] = 16'h0110; r_req[0] = 1'b1;
        @(negedge Clock);
        check("ad_lo_a", alu_a, 8'hF0);
        check("ad_lo_b", alu_b, 8'h10);
        @(negedge Clock);
        check("ad_hi_a", alu_a, 8'h12);
        check("ad_hi_b", alu_b, 8'h01);
        check("ad_hi_cin", alu_cin, 1);
        @(negedge Clock);
        check("ad_ack0", ack0, 1);
        check("ad_s", s, 16'h1400);
        check("ad_flags", flags, 3'b000);
        r_req[0] = 1'b0;
        @(negedge Clock);

        run_op(1, 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 3'b001, 0, "sb_wrap");
        run_op(1, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b011, 0, "ad_wrap");
        run_op(0, 3'd4, 16'h8000, 16'h0001, 16'h0001, 3'b100, 0, "ls_neg");
        run_op(0, 3'd4, 16'h0005, 16'hFFFF, 16'h0000, 3'b000, 0, "ls_pos");
        run_op(1, 3'd4, 16'h1234, 16'h1234, 16'h0000, 3'b000, 0, "ls_eq");
        run_op(0, 3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b000, 1, "rsv6");
        run_op(0, 3'd2, 16'h0F0F, 16'h00FF, 16'h000F, 3'b000, 1, "an_latch");
        run_op(1, 3'd3, 16'h1200, 16'h0034, 16'h1234, 3'b000, 0, "or");

        // Contended round-robin from reset
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_op[i] = 3'd0; r_a[i] = 16'h0100; r_b[i] = 16'(i + 1); r_req[i] = 1'b1;
        end
        k = 0; n = 0;
        while (k < 4 && n < 40) begin
            @(negedge Clock);
            n++;
            check("ack_overlap", ack0 & ack1, 0);
            if (ack0 || ack1) begin seq[k] = ack1 ? 1 : 0; k++; end
        end
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        check("rr_count", k, 4);
        for (int i = 0; i < k; i++) check("rr_order", seq[i], i % 2);
        repeat (4) @(negedge Clock);

        // Reset during the high pass
        r_op[0] = 3'd0; r_a[0] = 16'h0001; r_b[0] = 16'h0001; r_req[0] = 1'b1;
        repeat (2) @(negedge Clock);
        check("mid_busy", busy, 1);
        Reset = 1'b0;
        @(negedge Clock);
        check("mid_ack0", ack0, 0);
        check("mid_busy0", busy, 0);
        check("mid_s", s, 16'h0);
        check("mid_flags", flags, 3'b0);
        Reset = 1'b1;
        r_req[0] = 1'b0;
        run_op(0, 3'd0, 16'h0001, 16'h0001, 16'h0002, 3'b000, 0, "rereq");

        // Random traffic against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge Clock);
            if (!Reset) Reset = 1'b1;
            else if ($urandom_range(99) == 0) Reset = 1'b0;
            for (int i = 0; i < 2; i++) begin
                acked  = (i == 0) ? ack0 : ack1;
                in_srv = (m_phase != 0) && (m_g == i[0]);
                if (r_req[i] && acked) begin
                    if ($urandom_range(1) == 1) r_req[i] = 1'b0;
                    else new_operands(i);
                end else if (!r_req[i]) begin
                    if ($urandom_range(2) == 0) begin new_operands(i); r_req[i] = 1'b1; end
                end else if (!in_srv && $urandom_range(19) == 0) begin
                    r_req[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    new_operands(i);
                end
            end
        end
        Reset = 1'b1;
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        repeat (6) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
